// File: rtl/param_register_file_pkg.sv
// Shared state encoding and datapath-wide default sizes for the parametrised register file.
package param_register_file_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int unsigned DEF_DATA_W = 64;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_DEPTH  = 32;

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks the array writing zeros after reset or on Clear, then raises Ready.
module regfile_clear_seq
  import param_register_file_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clear,
  output logic              o_ready,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr
);

  localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(DEPTH - 1);

  state_e            r_state;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic              r_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_CLEAR;
      r_clr_ptr <= '0;
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (i_clear) begin
            r_clr_ptr <= '0;
          end else if (r_clr_ptr == LP_LAST) begin
            r_state   <= ST_READY;
            r_ready   <= 1'b1;
            r_clr_ptr <= '0;
          end else begin
            r_clr_ptr <= r_clr_ptr + 1'b1;
          end
        end
        ST_READY: begin
          if (i_clear) begin
            r_state   <= ST_CLEAR;
            r_clr_ptr <= '0;
            r_ready   <= 1'b0;
          end
        end
        default: r_state <= ST_CLEAR;
      endcase
    end
  end

  // Zeroing an entry on a restart cycle is harmless; the pointer rewinds regardless.
  assign o_clr_we   = (r_state == ST_CLEAR);
  assign o_clr_addr = r_clr_ptr;
  assign o_ready    = r_ready;

endmodule

// File: rtl/param_register_file.sv
// Parametrised single-write, dual-read register file with optional bypass and clear sequencer.
module param_register_file
  import param_register_file_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter bit          HAS_ZERO = 1'b1,
  parameter int unsigned ZERO_REG = 31,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Clear,
  output logic              Ready,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  output logic [DATA_W-1:0] BusA,
  output logic [DATA_W-1:0] BusB,
  input  logic [ADDR_W-1:0] RW,
  input  logic [DATA_W-1:0] BusW,
  input  logic              RegWr,
  output logic              WrDropped
);

  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LP_ZERO  = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic              r_wr_dropped;
  logic              w_ready;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_wr_en;
  logic              w_fwd;

  function automatic logic f_in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < LP_DEPTH;
  endfunction

  function automatic logic f_is_zero(input logic [ADDR_W-1:0] a);
    return HAS_ZERO && (a == LP_ZERO);
  endfunction

  regfile_clear_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clear_seq (
    .i_clk      (Clk),
    .i_reset    (Reset),
    .i_clear    (Clear),
    .o_ready    (w_ready),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr)
  );

  assign w_fwd   = RegWr && !Clear;
  assign w_wr_en = w_ready && w_fwd && !Reset && f_in_range(RW) && !f_is_zero(RW);

  always_ff @(posedge Clk) begin
    if (w_clr_we) begin
      r_regs[w_clr_addr] <= '0;
    end else if (w_wr_en) begin
      r_regs[RW] <= BusW;
    end
  end

  // Zero-register writes are ignored without flagging a drop.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_wr_dropped <= 1'b0;
    end else begin
      r_wr_dropped <= RegWr && (!w_ready || Clear || !f_in_range(RW));
    end
  end

  always_comb begin
    BusA = '0;
    if (w_ready && f_in_range(RA) && !f_is_zero(RA)) begin
      if (BYPASS && w_fwd && (RW == RA)) BusA = BusW;
      else                               BusA = r_regs[RA];
    end
  end

  always_comb begin
    BusB = '0;
    if (w_ready && f_in_range(RB) && !f_is_zero(RB)) begin
      if (BYPASS && w_fwd && (RW == RB)) BusB = BusW;
      else                               BusB = r_regs[RB];
    end
  end

  assign Ready     = w_ready;
  assign WrDropped = r_wr_dropped;

endmodule

// File: tb/tb_param_register_file.sv
// Four register-file configurations driven in lockstep and compared with an array-based model.
module tb_param_register_file;

  logic        clk = 1'b0;
  logic        reset, clear, reg_wr;
  logic [4:0]  ra, rb, rw;
  logic [63:0] bus_w;
  logic        rdy   [4];
  logic        wrd   [4];
  logic [63:0] bus_a [4];
  logic [63:0] bus_b [4];

  // 0: defaults, 1: BYPASS=0, 2: HAS_ZERO=0, 3: DEPTH=24
  int unsigned m_depth [4] = '{32, 32, 32, 24};
  bit          m_hz    [4] = '{1, 1, 0, 1};
  bit          m_byp   [4] = '{1, 0, 1, 1};
  logic [63:0] m_mem   [4][32];
  bit          m_rdy   [4];
  int          m_cnt   [4];
  bit          m_drop  [4];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  param_register_file u_def (
    .Clk(clk), .Reset(reset), .Clear(clear), .Ready(rdy[0]), .RA(ra), .RB(rb),
    .BusA(bus_a[0]), .BusB(bus_b[0]), .RW(rw), .BusW(bus_w), .RegWr(reg_wr), .WrDropped(wrd[0])
  );
  param_register_file #(.BYPASS(1'b0)) u_nobyp (
    .Clk(clk), .Reset(reset), .Clear(clear), .Ready(rdy[1]), .RA(ra), .RB(rb),
    .BusA(bus_a[1]), .BusB(bus_b[1]), .RW(rw), .BusW(bus_w), .RegWr(reg_wr), .WrDropped(wrd[1])
  );
  param_register_file #(.HAS_ZERO(1'b0)) u_nozero (
    .Clk(clk), .Reset(reset), .Clear(clear), .Ready(rdy[2]), .RA(ra), .RB(rb),
    .BusA(bus_a[2]), .BusB(bus_b[2]), .RW(rw), .BusW(bus_w), .RegWr(reg_wr), .WrDropped(wrd[2])
  );
  param_register_file #(.DEPTH(24)) u_d24 (
    .Clk(clk), .Reset(reset), .Clear(clear), .Ready(rdy[3]), .RA(ra), .RB(rb),
    .BusA(bus_a[3]), .BusB(bus_b[3]), .RW(rw), .BusW(bus_w), .RegWr(reg_wr), .WrDropped(wrd[3])
  );

  // Entering the clear phase is modelled as wiping the whole array at once.
  function automatic void model_wipe(input int k);
    for (int i = 0; i < 32; i++) m_mem[k][i] = '0;
    m_rdy[k] = 1'b0;
    m_cnt[k] = int'(m_depth[k]);
  endfunction

  function automatic void model_edge();
    for (int k = 0; k < 4; k++) begin
      if (reset) begin
        model_wipe(k);
        m_drop[k] = 1'b0;
      end else if (!m_rdy[k]) begin
        m_drop[k] = reg_wr;
        if (clear) m_cnt[k] = int'(m_depth[k]);
        else begin
          m_cnt[k]--;
          if (m_cnt[k] == 0) m_rdy[k] = 1'b1;
        end
      end else begin
        m_drop[k] = reg_wr && (clear || rw >= m_depth[k]);
        if (clear) model_wipe(k);
        else if (reg_wr && rw < m_depth[k] && !(m_hz[k] && rw == 31)) m_mem[k][rw] = bus_w;
      end
    end
  endfunction

  function automatic logic [63:0] exp_rd(input int k, input logic [4:0] a);
    if (!m_rdy[k] || a >= m_depth[k] || (m_hz[k] && a == 31)) return '0;
    if (m_byp[k] && reg_wr && !clear && rw == a) return bus_w;
    return m_mem[k][a];
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    reset = 0; clear = 0; reg_wr = 0; rw = 0; ra = 0; rb = 0; bus_w = '0;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 100 && !(rdy[0] && rdy[1] && rdy[2] && rdy[3]); i++) tick();
  endtask

  task automatic test_reset();
    int rise [4];
    idle();
    reset = 1;
    tick(); tick();
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (rdy[k] !== 1'b0 || wrd[k] !== 1'b0 || bus_a[k] !== '0) begin
        n_fail++;
        $display("FAIL reset_state inst%0d got rdy=%b wrd=%b a=%h want 0 0 0",
                 k, rdy[k], wrd[k], bus_a[k]);
      end
      rise[k] = 0;
    end
    reset = 0;
    for (int e = 1; e <= 60; e++) begin
      tick();
      for (int k = 0; k < 4; k++) begin
        if (rdy[k] === 1'b1 && rise[k] == 0) rise[k] = e;
        if (wrd[k] !== 1'b0) begin
          n_fail++;
          $display("FAIL wrdrop_in_clear inst%0d edge %0d got %b want 0", k, e, wrd[k]);
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (rise[k] != int'(m_depth[k])) begin
        n_fail++;
        $display("FAIL ready_latency inst%0d got %0d want %0d", k, rise[k], m_depth[k]);
      end
    end
    for (int a = 0; a < 32; a++) begin
      ra = 5'(a); rb = 5'(31 - a);
      #1;
      for (int k = 0; k < 4; k++) begin
        n_tests++;
        if (bus_a[k] !== '0 || bus_b[k] !== '0) begin
          n_fail++;
          $display("FAIL cleared_read inst%0d r%0d got %h/%h want 0", k, a, bus_a[k], bus_b[k]);
        end
      end
    end
  endtask

  task automatic test_write_bypass();
    idle();
    reg_wr = 1; rw = 3; bus_w = 64'hDEAD_BEEF_0123_4567; ra = 3;
    #1;
    n_tests++;
    if (bus_a[0] !== 64'hDEAD_BEEF_0123_4567) begin
      n_fail++;
      $display("FAIL bypass_on got %h want %h", bus_a[0], 64'hDEAD_BEEF_0123_4567);
    end
    n_tests++;
    if (bus_a[1] !== 64'h0) begin
      n_fail++;
      $display("FAIL bypass_off got %h want 0", bus_a[1]);
    end
    tick();
    reg_wr = 0; bus_w = '0;
    #1;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (bus_a[k] !== 64'hDEAD_BEEF_0123_4567) begin
        n_fail++;
        $display("FAIL write_r3 inst%0d got %h want %h", k, bus_a[k], 64'hDEAD_BEEF_0123_4567);
      end
    end
  endtask

  task automatic test_zero_reg();
    idle();
    reg_wr = 1; rw = 31; bus_w = '1;
    tick();
    reg_wr = 0; ra = 31; rb = 31;
    #1;
    n_tests++;
    if (bus_a[0] !== '0 || wrd[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_reg got a=%h wrd=%b want 0 0", bus_a[0], wrd[0]);
    end
    n_tests++;
    if (bus_b[2] !== '1 || wrd[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL no_zero_reg got b=%h wrd=%b want all-ones 0", bus_b[2], wrd[2]);
    end
  endtask

  task automatic test_depth_limit();
    idle();
    reg_wr = 1; rw = 28; bus_w = 64'h2828;
    tick();
    reg_wr = 0; ra = 28;
    #1;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (wrd[k] !== (k == 3) || bus_a[k] !== ((k == 3) ? 64'h0 : 64'h2828)) begin
        n_fail++;
        $display("FAIL depth_limit inst%0d got wrd=%b a=%h want %b %h", k, wrd[k], bus_a[k],
                 k == 3, (k == 3) ? 64'h0 : 64'h2828);
      end
    end
  endtask

  task automatic test_write_not_ready();
    idle();
    reset = 1; tick(); tick();
    reset = 0;
    for (int i = 0; i < 10; i++) tick();
    reg_wr = 1; rw = 5; bus_w = 64'h55;
    tick();
    reg_wr = 0;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (wrd[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL drop_not_ready inst%0d got %b want 1", k, wrd[k]);
      end
    end
    tick();
    n_tests++;
    if (wrd[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_pulse_width got %b want 0", wrd[0]);
    end
    wait_ready();
    ra = 5;
    #1;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (bus_a[k] !== '0 || rdy[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL r5_after_ready inst%0d got a=%h rdy=%b want 0 1", k, bus_a[k], rdy[k]);
      end
    end
  endtask

  task automatic test_clear();
    int rise;
    idle();
    reg_wr = 1; rw = 7; bus_w = 64'h77;
    tick();
    clear = 1; rw = 8; bus_w = 64'h88;
    tick();
    idle();
    n_tests++;
    if (wrd[0] !== 1'b1 || rdy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_drop got wrd=%b rdy=%b want 1 0", wrd[0], rdy[0]);
    end
    rise = 0;
    for (int e = 1; e <= 40 && rise == 0; e++) begin
      tick();
      if (rdy[0] === 1'b1) rise = e;
    end
    n_tests++;
    if (rise != 32) begin
      n_fail++;
      $display("FAIL clear_latency got %0d want 32", rise);
    end
    wait_ready();
    ra = 7; rb = 8;
    #1;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (bus_a[k] !== '0 || bus_b[k] !== '0) begin
        n_fail++;
        $display("FAIL clear_r7_r8 inst%0d got %h/%h want 0", k, bus_a[k], bus_b[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      reset  = ($urandom_range(0, 199) == 0);
      clear  = ($urandom_range(0, 63) == 0);
      reg_wr = $urandom_range(0, 1);
      rw     = 5'($urandom);
      ra     = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom);
      rb     = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom);
      bus_w  = {$urandom, $urandom};
      #1;
      for (int k = 0; k < 4; k++) begin
        n_tests++;
        if (rdy[k] !== m_rdy[k] || wrd[k] !== m_drop[k] ||
            bus_a[k] !== exp_rd(k, ra) || bus_b[k] !== exp_rd(k, rb)) begin
          n_fail++;
          $display("FAIL random c%0d inst%0d got rdy=%b wrd=%b a=%h b=%h want %b %b %h %h",
                   c, k, rdy[k], wrd[k], bus_a[k], bus_b[k],
                   m_rdy[k], m_drop[k], exp_rd(k, ra), exp_rd(k, rb));
        end
      end
      tick();
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_write_bypass();
    test_zero_reg();
    test_depth_limit();
    test_write_not_ready();
    test_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
